pe_pad_sched: RTL and testbench

Sequencing controller for one processing element (PE). It fills the input pad and weight pad through rdy/ack channels, then sweeps pad read addresses to stream operands into the multiply/sum pipeline. It drains the pipeline and hands the finished partial sum out through a rdy/ack channel. Input words are reused across `cfg_nfilt` filter passes, and only weights are reloaded per pass. The block sits between the PE's pad register files and its Fetch/Mult/Sum stages.

---
 rtl/pe_pad_sched_if.sv | 36 +++
 rtl/pe_pad_sched.sv | 194 +++++++++++++++++++
 tb/tb_pe_pad_sched.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pad_sched_if.sv
// Pad-fill, psum handoff and pad-port bundle between pe_pad_sched and its PE datapath.
// master = scheduler side, slave = producers/consumer and pad register files.
interface pe_pad_sched_if #(
    parameter int IPAD_DEPTH = 12
);
    localparam int AW = $clog2(IPAD_DEPTH);

    logic          i_Input_rdy;
    logic          o_Input_ack;
    logic          i_Weight_rdy;
    logic          o_Weight_ack;
    logic          o_Psum_rdy;
    logic          i_Psum_ack;
    logic          o_ip_write;
    logic [AW-1:0] o_ip_waddr;
    logic          o_wp_write;
    logic [AW-1:0] o_wp_waddr;
    logic          o_pad_read;
    logic [AW-1:0] o_pad_raddr;
    logic          o_mac_first;
    logic          o_mac_last;

    modport master (
        input  i_Input_rdy, i_Weight_rdy, i_Psum_ack,
        output o_Input_ack, o_Weight_ack, o_Psum_rdy,
        output o_ip_write, o_ip_waddr, o_wp_write, o_wp_waddr,
        output o_pad_read, o_pad_raddr, o_mac_first, o_mac_last
    );

    modport slave (
        output i_Input_rdy, i_Weight_rdy, i_Psum_ack,
        input  o_Input_ack, o_Weight_ack, o_Psum_rdy,
        input  o_ip_write, o_ip_waddr, o_wp_write, o_wp_waddr,
        input  o_pad_read, o_pad_raddr, o_mac_first, o_mac_last
    );
endinterface

// File: rtl/pe_pad_sched.sv
// PE sequencing controller: fill input/weight pads, sweep reads, drain pipeline, hand out psum.
// Optional saturating stall counter (o_stall_cnt) is built when PE_PAD_SCHED_PERF_EN is defined.
module pe_pad_sched #(
    parameter int IPAD_DEPTH = 12,
    parameter int NFILT_W    = 8,
    parameter int PIPE_LAT   = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [$clog2(IPAD_DEPTH+1)-1:0] i_cfg_ilen,
    input  logic [NFILT_W-1:0]              i_cfg_nfilt,
    output logic                            o_done,
    output logic                            o_cfg_err,
    output logic                            o_busy,
`ifdef PE_PAD_SCHED_PERF_EN
    output logic [15:0]                     o_stall_cnt,
`endif
    pe_pad_sched_if.master                  bus
);
    localparam int AW = $clog2(IPAD_DEPTH);
    localparam int CW = $clog2(IPAD_DEPTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_PSUM  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      ilen_q, ilen_d;
    logic [NFILT_W-1:0] nfilt_q, nfilt_d;
    logic [CW-1:0]      icnt_q, icnt_d;
    logic [CW-1:0]      wcnt_q, wcnt_d;
    logic [CW-1:0]      rcnt_q, rcnt_d;
    logic [3:0]         dcnt_q, dcnt_d;
    logic [NFILT_W-1:0] fcnt_q, fcnt_d;
    logic               load_in_q, load_in_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;

    logic in_pend, w_pend, in_ack, w_ack, ip_wr, wp_wr;
    logic cfg_bad, start_ok, in_done, w_done;

    // Input words are only fetched on the first pass; later passes reuse the input pad.
    assign in_pend  = load_in_q & (icnt_q < ilen_q);
    assign w_pend   = (wcnt_q < ilen_q);
    assign in_ack   = (state_q == S_LOAD) & in_pend;
    assign w_ack    = (state_q == S_LOAD) & w_pend;
    assign ip_wr    = bus.i_Input_rdy & in_ack;
    assign wp_wr    = bus.i_Weight_rdy & w_ack;

    assign cfg_bad  = (i_cfg_ilen == '0) || (i_cfg_ilen > CW'(IPAD_DEPTH)) || (i_cfg_nfilt == '0);
    assign start_ok = (state_q == S_IDLE) & i_start & ~cfg_bad;

    assign bus.o_Input_ack  = in_ack;
    assign bus.o_Weight_ack = w_ack;
    assign bus.o_ip_write   = ip_wr;
    assign bus.o_wp_write   = wp_wr;
    assign bus.o_ip_waddr   = icnt_q[AW-1:0];
    assign bus.o_wp_waddr   = wcnt_q[AW-1:0];
    assign bus.o_pad_read   = (state_q == S_READ);
    assign bus.o_pad_raddr  = rcnt_q[AW-1:0];
    assign bus.o_mac_first  = (state_q == S_READ) & (rcnt_q == '0);
    assign bus.o_mac_last   = (state_q == S_READ) & (rcnt_q == ilen_q - CW'(1));
    assign bus.o_Psum_rdy   = (state_q == S_PSUM);

    assign o_done    = done_q;
    assign o_cfg_err = cfg_err_q;
    assign o_busy    = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        ilen_d    = ilen_q;
        nfilt_d   = nfilt_q;
        icnt_d    = icnt_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        dcnt_d    = dcnt_q;
        fcnt_d    = fcnt_q;
        load_in_d = load_in_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        in_done   = 1'b0;
        w_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        ilen_d    = i_cfg_ilen;
                        nfilt_d   = i_cfg_nfilt;
                        icnt_d    = '0;
                        wcnt_d    = '0;
                        rcnt_d    = '0;
                        dcnt_d    = '0;
                        fcnt_d    = '0;
                        load_in_d = 1'b1;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (ip_wr) icnt_d = icnt_q + CW'(1);
                if (wp_wr) wcnt_d = wcnt_q + CW'(1);
                // Leave as soon as the final transfer lands, so READ starts the very next cycle.
                in_done = ~load_in_q | (icnt_d == ilen_q);
                w_done  = (wcnt_d == ilen_q);
                if (in_done && w_done) begin
                    rcnt_d  = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (rcnt_q == ilen_q - CW'(1)) begin
                    rcnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = (PIPE_LAT == 1) ? S_PSUM : S_DRAIN;
                end else begin
                    rcnt_d = rcnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (dcnt_q == 4'(PIPE_LAT - 2)) state_d = S_PSUM;
                else                            dcnt_d  = dcnt_q + 4'd1;
            end
            S_PSUM: begin
                if (bus.i_Psum_ack) begin
                    if (fcnt_q == nfilt_q - NFILT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fcnt_d    = fcnt_q + NFILT_W'(1);
                        wcnt_d    = '0;
                        load_in_d = 1'b0;
                        state_d   = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            ilen_q    <= '0;
            nfilt_q   <= '0;
            icnt_q    <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            dcnt_q    <= '0;
            fcnt_q    <= '0;
            load_in_q <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ilen_q    <= ilen_d;
            nfilt_q   <= nfilt_d;
            icnt_q    <= icnt_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            dcnt_q    <= dcnt_d;
            fcnt_q    <= fcnt_d;
            load_in_q <= load_in_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef PE_PAD_SCHED_PERF_EN
    logic [15:0] stall_q, stall_d;
    logic        stall_cyc;

    // In LOAD every acked channel has words pending, so "no write" means a stall.
    assign stall_cyc = ((state_q == S_LOAD) & ~ip_wr & ~wp_wr) |
                       ((state_q == S_PSUM) & ~bus.i_Psum_ack);

    always_comb begin
        stall_d = stall_q;
        if (start_ok)                            stall_d = '0;
        else if (stall_cyc && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign o_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_pe_pad_sched.sv
// Directed bench for pe_pad_sched: single pass, multi-filter reuse, backpressure, boundaries, reset.
module tb_pe_pad_sched;
    localparam int IPAD_DEPTH = 12;
    localparam int NFILT_W    = 8;
    localparam int PIPE_LAT   = 3;
    localparam int CW         = $clog2(IPAD_DEPTH + 1);

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_start;
    logic [CW-1:0]      i_cfg_ilen;
    logic [NFILT_W-1:0] i_cfg_nfilt;
    logic               o_done;
    logic               o_cfg_err;
    logic               o_busy;
`ifdef PE_PAD_SCHED_PERF_EN
    logic [15:0]        o_stall_cnt;
`endif

    pe_pad_sched_if #(.IPAD_DEPTH(IPAD_DEPTH)) bus ();

    pe_pad_sched #(
        .IPAD_DEPTH(IPAD_DEPTH),
        .NFILT_W   (NFILT_W),
        .PIPE_LAT  (PIPE_LAT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_cfg_ilen (i_cfg_ilen),
        .i_cfg_nfilt(i_cfg_nfilt),
        .o_done     (o_done),
        .o_cfg_err  (o_cfg_err),
        .o_busy     (o_busy),
`ifdef PE_PAD_SCHED_PERF_EN
        .o_stall_cnt(o_stall_cnt),
`endif
        .bus        (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Transaction monitor, sampled mid-cycle on the falling edge.
    int in_xfer = 0, w_xfer = 0, ps_hs = 0, done_cnt = 0, in_ack_cyc = 0;
    int max_raddr = 0, max_ipa = 0, max_wpa = 0;
    always @(negedge i_clk) begin
        if (bus.o_ip_write) begin
            in_xfer <= in_xfer + 1;
            if (int'(bus.o_ip_waddr) > max_ipa) max_ipa <= int'(bus.o_ip_waddr);
        end
        if (bus.o_wp_write) begin
            w_xfer <= w_xfer + 1;
            if (int'(bus.o_wp_waddr) > max_wpa) max_wpa <= int'(bus.o_wp_waddr);
        end
        if (bus.o_pad_read && int'(bus.o_pad_raddr) > max_raddr) max_raddr <= int'(bus.o_pad_raddr);
        if (bus.o_Psum_rdy && bus.i_Psum_ack) ps_hs <= ps_hs + 1;
        if (o_done) done_cnt <= done_cnt + 1;
        if (bus.o_Input_ack) in_ack_cyc <= in_ack_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_start(input int ilen, input int nfilt);
        i_cfg_ilen  = CW'(ilen);
        i_cfg_nfilt = NFILT_W'(nfilt);
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic wait_psum_rdy(input string tag, input int budget);
        int n = 0;
        while (!bus.o_Psum_rdy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, bus.o_Psum_rdy, 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, o_done, 1);
        tick();
    endtask

    // Hold Psum ack low for 'hold' cycles of rdy, then accept.
    task automatic finish_psum(input string tag, input int hold);
        wait_psum_rdy(tag, 60);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_rdy_hold"}, bus.o_Psum_rdy, 1);
            tick();
        end
        bus.i_Psum_ack = 1'b1;
        chk({tag, "_rdy_at_ack"}, bus.o_Psum_rdy, 1);
        tick();
        bus.i_Psum_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b_in, b_w, b_ps, b_done, b_ack;

        i_rst = 1'b1; i_start = 1'b0; i_cfg_ilen = '0; i_cfg_nfilt = '0;
        bus.i_Input_rdy = 1'b0; bus.i_Weight_rdy = 1'b0; bus.i_Psum_ack = 1'b0;
        tick(); tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_in_ack", bus.o_Input_ack, 0);
        chk("rst_psum_rdy", bus.o_Psum_rdy, 0);
        chk("rst_done", o_done, 0);
        i_rst = 1'b0;
        tick();

        // Single pass, ilen=4, everything always ready.
        $display("T1 single pass ilen=4 nfilt=1");
        bus.i_Input_rdy = 1'b1; bus.i_Weight_rdy = 1'b1; bus.i_Psum_ack = 1'b1;
        b_done = done_cnt;
        do_start(4, 1);
        chk("t1_busy", o_busy, 1);
        chk("t1_in_ack", bus.o_Input_ack, 1);
        chk("t1_w_ack", bus.o_Weight_ack, 1);
        for (int k = 0; k < 4; k++) begin
            chk("t1_ip_write", bus.o_ip_write, 1);
            chk("t1_ip_waddr", bus.o_ip_waddr, k);
            chk("t1_wp_waddr", bus.o_wp_waddr, k);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk("t1_read", bus.o_pad_read, 1);
            chk("t1_raddr", bus.o_pad_raddr, k);
            chk("t1_first", bus.o_mac_first, (k == 0));
            chk("t1_last", bus.o_mac_last, (k == 3));
            chk("t1_no_in_ack", bus.o_Input_ack, 0);
            tick();
        end
        n = 4;
        while (!bus.o_Psum_rdy && n < 50) begin
            tick();
            n++;
        end
        chk("t1_psum_latency", n, 6);
        tick();
        chk("t1_done", o_done, 1);
        chk("t1_idle", o_busy, 0);
        tick();
        chk("t1_done_pulse", o_done, 0);
        chk("t1_done_count", done_cnt - b_done, 1);

        // Three filter passes over one input load.
        $display("T2 multi-filter ilen=3 nfilt=3");
        b_in = in_xfer; b_w = w_xfer; b_ps = ps_hs; b_ack = in_ack_cyc; b_done = done_cnt;
        do_start(3, 3);
        wait_done("t2_done", 100);
        chk("t2_in_xfer", in_xfer - b_in, 3);
        chk("t2_w_xfer", w_xfer - b_w, 9);
        chk("t2_psum_hs", ps_hs - b_ps, 3);
        chk("t2_in_ack_cycles", in_ack_cyc - b_ack, 3);
        chk("t2_done_count", done_cnt - b_done, 1);

        // Psum ack held off for 5 cycles.
        $display("T3a psum backpressure ilen=2");
        bus.i_Psum_ack = 1'b0;
        b_ps = ps_hs;
        do_start(2, 1);
        finish_psum("t3a", 5);
        chk("t3a_done", o_done, 1);
        chk("t3a_idle", o_busy, 0);
        chk("t3a_psum_hs", ps_hs - b_ps, 1);
`ifdef PE_PAD_SCHED_PERF_EN
        chk("t3a_stall", o_stall_cnt, 5);
`endif
        tick();

        // Input rdy on odd cycles only, weights continuous.
        $display("T3b input gaps ilen=4");
        bus.i_Psum_ack = 1'b1;
        do_start(4, 1);
        for (int k = 0; k < 8; k++) begin
            bus.i_Input_rdy = (k % 2 == 1);
            chk("t3b_not_read", bus.o_pad_read, 0);
            if (k == 7) chk("t3b_last_waddr", bus.o_ip_waddr, 3);
            tick();
        end
        bus.i_Input_rdy = 1'b1;
        chk("t3b_read_start", bus.o_pad_read, 1);
        chk("t3b_first", bus.o_mac_first, 1);
        chk("t3b_read_in_ack", bus.o_Input_ack, 0);
        wait_done("t3b_done", 40);
`ifdef PE_PAD_SCHED_PERF_EN
        chk("t3b_stall", o_stall_cnt, 2);
`endif

        // ilen=1: first and last coincide.
        $display("T4a ilen=1");
        do_start(1, 1);
        tick();
        chk("t4a_read", bus.o_pad_read, 1);
        chk("t4a_first", bus.o_mac_first, 1);
        chk("t4a_last", bus.o_mac_last, 1);
        wait_done("t4a_done", 20);

        // Full pad.
        $display("T4b ilen=12");
        b_in = in_xfer;
        do_start(12, 1);
        wait_done("t4b_done", 60);
        chk("t4b_in_xfer", in_xfer - b_in, 12);
        chk("t4b_max_raddr", max_raddr, 11);
        chk("t4b_max_ipa", max_ipa, 11);
        chk("t4b_max_wpa", max_wpa, 11);

        // Illegal configurations.
        $display("T4c illegal configs");
        do_start(0, 1);
        chk("t4c_err_ilen0", o_cfg_err, 1);
        chk("t4c_busy_ilen0", o_busy, 0);
        tick();
        chk("t4c_err_pulse", o_cfg_err, 0);
        do_start(3, 0);
        chk("t4c_err_nfilt0", o_cfg_err, 1);
        chk("t4c_busy_nfilt0", o_busy, 0);
        chk("t4c_no_ack", bus.o_Weight_ack, 0);
        tick();
        do_start(13, 1);
        chk("t4c_err_ilen13", o_cfg_err, 1);
        chk("t4c_busy_ilen13", o_busy, 0);
        tick();

        // Reset during READ at rcnt=2, then a clean two-pass run.
        $display("T5 reset mid-read");
        do_start(4, 1);
        for (int k = 0; k < 6; k++) tick();
        chk("t5_raddr_before", bus.o_pad_raddr, 2);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("t5_busy", o_busy, 0);
        chk("t5_read", bus.o_pad_read, 0);
        chk("t5_raddr", bus.o_pad_raddr, 0);
        chk("t5_in_ack", bus.o_Input_ack, 0);
        chk("t5_w_ack", bus.o_Weight_ack, 0);
        chk("t5_ip_waddr", bus.o_ip_waddr, 0);
        chk("t5_first", bus.o_mac_first, 0);
        chk("t5_psum_rdy", bus.o_Psum_rdy, 0);
        chk("t5_done", o_done, 0);
`ifdef PE_PAD_SCHED_PERF_EN
        chk("t5_stall_rst", o_stall_cnt, 0);
`endif
        bus.i_Psum_ack = 1'b0;
        b_ps = ps_hs;
        do_start(3, 2);
        finish_psum("t5_p0", 3);
        finish_psum("t5_p1", 3);
        chk("t5_done_after", o_done, 1);
        chk("t5_psum_hs", ps_hs - b_ps, 2);
`ifdef PE_PAD_SCHED_PERF_EN
        chk("t5_stall", o_stall_cnt, 6);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
